// File: rtl/ddr2_bridge.sv
// Bridges one-cycle cache line requests to a DDR2 memory controller's app interface.
// Requests are queued in a small FIFO and issued one at a time, strictly in order.
module ddr2_bridge #(
    parameter int REQ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ddr2_enable,
    input  logic         ddr2_read,
    input  logic [26:0]  ddr2_addr,
    input  logic [127:0] to_ddr2_data,
    output logic         ddr2_available,
    output logic [127:0] ddr2_data,
    output logic         busy,
    output logic         err_overflow,
    input  logic         init_calib_complete,
    output logic [26:0]  app_addr,
    output logic [2:0]   app_cmd,
    output logic         app_en,
    input  logic         app_rdy,
    output logic [127:0] app_wdf_data,
    output logic [15:0]  app_wdf_mask,
    output logic         app_wdf_wren,
    output logic         app_wdf_end,
    input  logic         app_wdf_rdy,
    input  logic [127:0] app_rd_data,
    input  logic         app_rd_data_valid
);

    localparam int PW = (REQ_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam int EW = 1 + 23 + 128;
    localparam logic [CW-1:0] FULL_CNT = CW'(REQ_DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [PW-1:0] LAST_PTR = PW'(REQ_DEPTH - 1);
    localparam logic [PW-1:0] ONE_PTR  = PW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_CMD  = 2'd2,
        RD_WAIT = 2'd3
    } state_t;

    logic [EW-1:0]  fifo_mem_r [REQ_DEPTH];
    logic [PW-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           full_s, empty_s, pop_s, push_s, drop_s;
    logic [EW-1:0]  head_s;

    state_t         state_r, state_n;
    logic           app_en_r, app_en_n;
    logic [2:0]     app_cmd_r, app_cmd_n;
    logic [26:0]    app_addr_r, app_addr_n;
    logic [127:0]   wdf_data_r, wdf_data_n;
    logic           wdf_wren_r, wdf_wren_n;
    logic           wdf_end_r, wdf_end_n;
    logic           en_done_r, en_done_n;
    logic           wdf_done_r, wdf_done_n;
    logic [127:0]   rd_data_r, rd_data_n;
    logic           avail_r, avail_n;
    logic           err_overflow_r;

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign full_s  = (count_r == FULL_CNT);
    assign empty_s = (count_r == {CW{1'b0}});
    assign pop_s   = (state_r == IDLE) && !empty_s && init_calib_complete;
    assign push_s  = ddr2_enable && (!full_s || pop_s);
    assign drop_s  = ddr2_enable && full_s && !pop_s;
    assign head_s  = fifo_mem_r[rd_ptr_r];

    // FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r       <= {PW{1'b0}};
            rd_ptr_r       <= {PW{1'b0}};
            count_r        <= {CW{1'b0}};
            err_overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + ONE_CNT;
                2'b01:   count_r <= count_r - ONE_CNT;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                err_overflow_r <= 1'b1;
            end
        end
    end

    // FIFO storage; entries are only meaningful below count_r, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {ddr2_read, ddr2_addr[26:4], to_ddr2_data};
        end
    end

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_n    = state_r;
        app_en_n   = app_en_r;
        app_cmd_n  = app_cmd_r;
        app_addr_n = app_addr_r;
        wdf_data_n = wdf_data_r;
        wdf_wren_n = wdf_wren_r;
        wdf_end_n  = wdf_end_r;
        en_done_n  = en_done_r;
        wdf_done_n = wdf_done_r;
        rd_data_n  = rd_data_r;
        avail_n    = 1'b0;
        case (state_r)
            IDLE: begin
                if (pop_s) begin
                    app_en_n   = 1'b1;
                    app_addr_n = {head_s[150:128], 4'b0000};
                    en_done_n  = 1'b0;
                    wdf_done_n = 1'b0;
                    if (head_s[151]) begin
                        state_n   = RD_CMD;
                        app_cmd_n = 3'b001;
                    end else begin
                        state_n    = WR;
                        app_cmd_n  = 3'b000;
                        wdf_data_n = head_s[127:0];
                        wdf_wren_n = 1'b1;
                        wdf_end_n  = 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WR: begin
                // Command and data handshakes complete independently, in either order.
                if (app_en_r && app_rdy) begin
                    app_en_n  = 1'b0;
                    en_done_n = 1'b1;
                end else begin
                    app_en_n  = app_en_r;
                    en_done_n = en_done_r;
                end
                if (wdf_wren_r && app_wdf_rdy) begin
                    wdf_wren_n = 1'b0;
                    wdf_end_n  = 1'b0;
                    wdf_done_n = 1'b1;
                end else begin
                    wdf_wren_n = wdf_wren_r;
                    wdf_end_n  = wdf_end_r;
                    wdf_done_n = wdf_done_r;
                end
                if (en_done_n && wdf_done_n) begin
                    state_n = IDLE;
                end else begin
                    state_n = WR;
                end
            end
            RD_CMD: begin
                if (app_rdy) begin
                    app_en_n = 1'b0;
                    state_n  = RD_WAIT;
                end else begin
                    state_n = RD_CMD;
                end
            end
            RD_WAIT: begin
                if (app_rd_data_valid) begin
                    rd_data_n = app_rd_data;
                    avail_n   = 1'b1;
                    state_n   = IDLE;
                end else begin
                    state_n = RD_WAIT;
                end
            end
            default: begin
                state_n    = IDLE;
                app_en_n   = 1'b0;
                wdf_wren_n = 1'b0;
                wdf_end_n  = 1'b0;
            end
        endcase
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            app_en_r   <= 1'b0;
            app_cmd_r  <= 3'b000;
            app_addr_r <= 27'd0;
            wdf_data_r <= 128'd0;
            wdf_wren_r <= 1'b0;
            wdf_end_r  <= 1'b0;
            en_done_r  <= 1'b0;
            wdf_done_r <= 1'b0;
            rd_data_r  <= 128'd0;
            avail_r    <= 1'b0;
        end else begin
            state_r    <= state_n;
            app_en_r   <= app_en_n;
            app_cmd_r  <= app_cmd_n;
            app_addr_r <= app_addr_n;
            wdf_data_r <= wdf_data_n;
            wdf_wren_r <= wdf_wren_n;
            wdf_end_r  <= wdf_end_n;
            en_done_r  <= en_done_n;
            wdf_done_r <= wdf_done_n;
            rd_data_r  <= rd_data_n;
            avail_r    <= avail_n;
        end
    end

    assign ddr2_available = avail_r;
    assign ddr2_data      = rd_data_r;
    assign busy           = full_s;
    assign err_overflow   = err_overflow_r;
    assign app_addr       = app_addr_r;
    assign app_cmd        = app_cmd_r;
    assign app_en         = app_en_r;
    assign app_wdf_data   = wdf_data_r;
    assign app_wdf_mask   = 16'h0000;
    assign app_wdf_wren   = wdf_wren_r;
    assign app_wdf_end    = wdf_end_r;

endmodule

// File: doc/ddr2_bridge.md
DDR2_BRIDGE -- requirements
Module: ddr2_bridge

Interface
REQ-001 SHALL have parameter REQ_DEPTH, default 2, giving the request FIFO depth in entries; legal values are 2 and 4.
REQ-002 SHALL have one clock and an asynchronous active-low reset: clk, rst_n.
REQ-003 Port clk  in  1: rising-edge clock for all state.
REQ-004 Port rst_n  in  1: asynchronous active-low reset.
REQ-005 Port ddr2_enable  in  1: one-cycle request strobe from the cache.
REQ-006 Port ddr2_read  in  1: 1 = line read, 0 = line write; qualified by ddr2_enable.
REQ-007 Port ddr2_addr  in  27: byte address; bits [3:0] ignored.
REQ-008 Port to_ddr2_data  in  128: write line; qualified by ddr2_enable with ddr2_read=0.
REQ-009 Port ddr2_available  out  1: one-cycle pulse when read data is valid.
REQ-010 Port ddr2_data  out  128: read line; held until the next read completes.
REQ-011 Port busy  out  1: request FIFO full.
REQ-012 Port err_overflow  out  1: sticky flag set when a request is dropped.
REQ-013 Port init_calib_complete  in  1: the memory controller is ready.
REQ-014 Ports app_addr out 27, app_cmd out 3, app_en out 1, app_rdy in 1: command channel.
REQ-015 Ports app_wdf_data out 128, app_wdf_mask out 16, app_wdf_wren out 1, app_wdf_end out 1, app_wdf_rdy in 1: write-data channel.
REQ-016 Ports app_rd_data in 128, app_rd_data_valid in 1: read-return channel.

Function
REQ-017 SHALL push {read, addr[26:4], data} into the FIFO on every cycle with ddr2_enable=1 and the FIFO not full, with no wait states.
REQ-018 SHALL accept a write request followed by a read request on the next cycle without loss.
REQ-019 SHALL accept a push on a cycle where the FIFO is full but a pop occurs in that same cycle.
REQ-020 SHALL drop a request that arrives while the FIFO is full with no pop in that cycle, and set err_overflow until reset.
REQ-021 SHALL have FSM states IDLE, WR, RD_CMD and RD_WAIT.
REQ-022 In IDLE, the FSM SHALL pop the head entry only when the FIFO is non-empty and init_calib_complete=1, then go to WR (write entry) or RD_CMD (read entry).
REQ-023 SHALL drive app_addr = {entry_addr[26:4], 4'b0000} in WR and RD_CMD.
REQ-024 In WR, SHALL assert app_en=1 with app_cmd=3'b000, and app_wdf_wren=1 and app_wdf_end=1 with app_wdf_mask=16'h0000 and app_wdf_data set to the entry data.
REQ-025 In WR, SHALL drop app_en after the first cycle with app_rdy=1 and drop wdf_wren/end after the first cycle with app_wdf_rdy=1, tracking each with its own done flag.
REQ-026 SHALL leave WR for IDLE once both done flags are set, including when both handshakes complete in the same cycle.
REQ-027 SHALL NOT pulse ddr2_available for a write.
REQ-028 In RD_CMD, SHALL assert app_en=1 with app_cmd=3'b001 until app_rdy=1, then go to RD_WAIT.
REQ-029 In RD_WAIT, on app_rd_data_valid=1, SHALL register app_rd_data into ddr2_data, pulse ddr2_available the next cycle, and return to IDLE.
REQ-030 Minimum read latency SHALL be ddr2_enable -> app_en 2 cycles; app_rd_data_valid -> ddr2_available 1 cycle.
REQ-031 SHALL ignore app_rd_data_valid in any state other than RD_WAIT.
REQ-032 SHALL keep only one command outstanding at a time; requests are serviced strictly in order.
REQ-033 busy SHALL be combinational and equal to FIFO count == REQ_DEPTH.
REQ-034 FIFO pointers SHALL wrap modulo REQ_DEPTH.

Reset
REQ-035 On rst_n=0, SHALL immediately set state IDLE and FIFO empty.
REQ-036 On rst_n=0, SHALL clear ddr2_available, app_en, app_wdf_wren, app_wdf_end, err_overflow and busy to 0.
REQ-037 On rst_n=0, SHALL clear ddr2_data, app_addr, app_cmd and app_wdf_data to 0.
REQ-038 A reset mid-transaction SHALL abandon the transaction; no ddr2_available pulse SHALL follow from a pre-reset read.

Verification
REQ-039 Read, app_rdy=1, data returned 10 cycles later: read addr 27'h0001230 -> app_addr 27'h0001230, cmd 001; ddr2_data=128'hDEAD..BEEF with one ddr2_available pulse.
REQ-040 Write then read on back-to-back cycles: write addr 27'h0000010 with data 128'h11..11, then read addr 27'h4000010 -> write issued first, then read; exactly one ddr2_available pulse.
REQ-041 Write with app_rdy=1 at cycle 1 and app_wdf_rdy=1 at cycle 4 -> app_en drops after cycle 1, wdf_wren drops after cycle 4, FSM returns to IDLE afterwards.
REQ-042 Three requests pushed while init_calib_complete=0 with REQ_DEPTH=2 -> busy=1 after two, third dropped, err_overflow=1; two commands issued after calibration.
REQ-043 rst_n pulsed low in RD_WAIT, then a stray app_rd_data_valid -> no ddr2_available pulse, all outputs 0.
REQ-044 Address with low bits 4'hF, 27'h000003F -> app_addr=27'h0000030.
